usb_uart_buffer: RTL and testbench

USB_UART_BUFFER -- requirements
Module: usb_uart_buffer

---
 rtl/usb_uart_pkg.sv | 16 +
 rtl/usb_uart_buffer_fifo.sv | 52 +++++
 rtl/usb_uart_buffer.sv | 130 +++++++++++++
 tb/tb_usb_uart_buffer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_uart_pkg.sv
// Shared constants and TX state encoding for the USB UART byte buffer.
// Imported by usb_uart_buffer.
package usb_uart_pkg;

  localparam int TX_DEPTH_DEF    = 64;
  localparam int RX_DEPTH_DEF    = 64;
  localparam int TX_HOLD_LEN_DEF = 32;
  localparam int TX_TIMEOUT_DEF  = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } tx_state_t;

endpackage

// File: rtl/usb_uart_buffer_fifo.sv
// usb_byte_fifo: first-word-fall-through byte FIFO with occupancy count.
// Ports: i_clk/i_rst, i_push/i_data, i_pop, o_data (0 when empty), o_full, o_empty, o_level.
module usb_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  logic        w_push;
  logic        w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = o_empty ? 8'h00 : r_mem[r_rd];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/usb_uart_buffer.sv
// Byte buffer between a user UART-like stream and a USB CDC core.
// TX path holds bytes into bursts (length/timeout/flush); RX path backpressures or drops.
// Ports: clk_48mhz, reset; uart_in_*, core_in_*, core_out_*, uart_out_* streams;
// tx_flush; tx_level, rx_level occupancy; rx_overflow_count dropped RX bytes.
module usb_uart_buffer
  import usb_uart_pkg::*;
#(
  parameter int TX_DEPTH    = TX_DEPTH_DEF,
  parameter int RX_DEPTH    = RX_DEPTH_DEF,
  parameter int TX_HOLD_LEN = TX_HOLD_LEN_DEF,
  parameter int TX_TIMEOUT  = TX_TIMEOUT_DEF,
  parameter int RX_DROP     = 0
) (
  input  logic                        clk_48mhz,
  input  logic                        reset,
  input  logic [7:0]                  uart_in_data,
  input  logic                        uart_in_valid,
  output logic                        uart_in_ready,
  output logic [7:0]                  core_in_data,
  output logic                        core_in_valid,
  input  logic                        core_in_ready,
  input  logic [7:0]                  core_out_data,
  input  logic                        core_out_valid,
  output logic                        core_out_ready,
  output logic [7:0]                  uart_out_data,
  output logic                        uart_out_valid,
  input  logic                        uart_out_ready,
  input  logic                        tx_flush,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic [15:0]                 rx_overflow_count
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TW  = $clog2(TX_TIMEOUT) + 1;
  localparam logic [TAW:0]  L_HOLD = (TAW+1)'(TX_HOLD_LEN);
  localparam logic [TW-1:0] L_TMAX = TW'(TX_TIMEOUT - 1);
  localparam logic [TAW:0]  L_ONE  = (TAW+1)'(1);

  tx_state_t     r_state;
  tx_state_t     w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [15:0]   r_ovf;
  logic          r_rdy_en;

  logic       w_tx_full;
  logic       w_tx_empty;
  logic [7:0] w_tx_head;
  logic       w_rx_full;
  logic       w_rx_empty;
  logic       w_tx_push;
  logic       w_tx_pop;
  logic       w_rx_push;
  logic       w_rx_pop;
  logic       w_rx_drop;

  // Readies stay low through reset and for the first cycle after it.
  assign uart_in_ready  = r_rdy_en && !w_tx_full;
  assign core_out_ready = r_rdy_en && ((RX_DROP != 0) || !w_rx_full);
  assign core_in_valid  = (r_state == DRAIN) && !w_tx_empty;
  assign core_in_data   = core_in_valid ? w_tx_head : 8'h00;
  assign uart_out_valid = !w_rx_empty;
  assign rx_overflow_count = r_ovf;

  assign w_tx_push = uart_in_valid && uart_in_ready;
  assign w_tx_pop  = core_in_valid && core_in_ready;
  assign w_rx_pop  = uart_out_valid && uart_out_ready;
  assign w_rx_push = core_out_valid && core_out_ready;
  assign w_rx_drop = (RX_DROP != 0) && w_rx_push && w_rx_full && !w_rx_pop;

  usb_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk   (clk_48mhz),
    .i_rst   (reset),
    .i_push  (w_tx_push),
    .i_data  (uart_in_data),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_level (tx_level)
  );

  usb_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk   (clk_48mhz),
    .i_rst   (reset),
    .i_push  (w_rx_push),
    .i_data  (core_out_data),
    .i_pop   (w_rx_pop),
    .o_data  (uart_out_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_level (rx_level)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_tx_push) w_state_nxt = (TX_HOLD_LEN == 0) ? DRAIN : HOLD;
      end
      HOLD: begin
        if (tx_level >= L_HOLD || r_timer == L_TMAX || tx_flush)
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // A write alongside the final pop keeps the burst going.
        if (w_tx_pop && tx_level == L_ONE && !w_tx_push)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_ovf    <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
      // Outside HOLD the timer sits at zero, so HOLD is always entered cleared.
      if (w_tx_push || r_state != HOLD) r_timer <= '0;
      else if (r_timer != L_TMAX)       r_timer <= r_timer + 1'b1;
      if (w_rx_drop && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 16'd1;
    end
  end

endmodule

// File: tb/tb_usb_uart_buffer.sv
// Directed self-checking bench for usb_uart_buffer.
// Instance A uses RX backpressure, instance B uses RX drop mode.
module tb_usb_uart_buffer;
  import usb_uart_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] uart_in_data = 8'h00;
  logic uart_in_valid = 1'b0;
  logic core_in_ready = 1'b0;
  logic [7:0] core_out_data = 8'h00;
  logic core_out_valid = 1'b0;
  logic uart_out_ready = 1'b0;
  logic tx_flush = 1'b0;
  logic [7:0] core_out_data_b = 8'h00;
  logic core_out_valid_b = 1'b0;
  logic uart_out_ready_b = 1'b0;

  logic uir, civ, cor, uov;
  logic [7:0] cid, uod;
  logic [6:0] txl, rxl;
  logic [15:0] ovf;
  logic uir_b, civ_b, cor_b, uov_b;
  logic [7:0] cid_b, uod_b;
  logic [6:0] txl_b, rxl_b;
  logic [15:0] ovf_b;

  int n_tests = 0;
  int n_fail = 0;
  int civ_seen = 0;

  always #5 clk = ~clk;

  usb_uart_buffer dut_a (
    .clk_48mhz(clk), .reset(reset),
    .uart_in_data(uart_in_data), .uart_in_valid(uart_in_valid),
    .uart_in_ready(uir),
    .core_in_data(cid), .core_in_valid(civ), .core_in_ready(core_in_ready),
    .core_out_data(core_out_data), .core_out_valid(core_out_valid),
    .core_out_ready(cor),
    .uart_out_data(uod), .uart_out_valid(uov), .uart_out_ready(uart_out_ready),
    .tx_flush(tx_flush), .tx_level(txl), .rx_level(rxl),
    .rx_overflow_count(ovf)
  );

  usb_uart_buffer #(.RX_DROP(1)) dut_b (
    .clk_48mhz(clk), .reset(reset),
    .uart_in_data(uart_in_data), .uart_in_valid(uart_in_valid),
    .uart_in_ready(uir_b),
    .core_in_data(cid_b), .core_in_valid(civ_b), .core_in_ready(core_in_ready),
    .core_out_data(core_out_data_b), .core_out_valid(core_out_valid_b),
    .core_out_ready(cor_b),
    .uart_out_data(uod_b), .uart_out_valid(uov_b),
    .uart_out_ready(uart_out_ready_b),
    .tx_flush(tx_flush), .tx_level(txl_b), .rx_level(rxl_b),
    .rx_overflow_count(ovf_b)
  );

  typedef struct {
    logic rst, iv;
    logic [7:0] id;
    logic fl, cir, cov;
    logic [7:0] cod;
    logic uor;
    logic e_uir, e_civ;
    logic [7:0] e_cid;
    logic e_cor, e_uov;
    logic [7:0] e_uod;
    logic [6:0] e_txl, e_rxl;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    uart_in_valid = 1'b0;
    core_in_ready = 1'b0;
    core_out_valid = 1'b0;
    uart_out_ready = 1'b0;
    tx_flush = 1'b0;
    core_out_valid_b = 1'b0;
    uart_out_ready_b = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic write_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      uart_in_valid = 1'b1;
      uart_in_data = base + 8'(i);
      #1;
      if (civ) civ_seen++;
      @(posedge clk);
      #1;
    end
    uart_in_valid = 1'b0;
  endtask

  task automatic collect_tx(input int n, input logic [7:0] base,
                            input string tag);
    for (int k = 0; k < n; k++) begin
      int w = 0;
      while (!civ && w < 1000) begin
        @(posedge clk);
        #1;
        w++;
      end
      check({tag, "_valid"}, 32'(civ), 32'(1));
      if (!civ) return;
      check({tag, "_data"}, 32'(cid), 32'(base + 8'(k)));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cnt;
    int idx_a, idx_b, got_a, got_b;
    logic ra, rb, va, vb;
    logic [7:0] da, db;

    //            rst   iv    id     fl    cir   cov   cod    uor
    //            uir   civ   cid    cor   uov   uod    txl   rxl
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0,
                 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 7'd0, 7'd0};
    vecs[1]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0,
                 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 7'd0, 7'd0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0,
                 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 7'd0, 7'd0};
    vecs[3]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'hC1, 1'b0,
                 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 7'd0, 7'd0};
    vecs[4]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hC2, 1'b1,
                 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hC1, 7'd1, 7'd1};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1,
                 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hC2, 7'd2, 7'd1};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0,
                 1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 8'h00, 7'd2, 7'd0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0,
                 1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 8'h00, 7'd2, 7'd0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0,
                 1'b1, 1'b1, 8'hA2, 1'b1, 1'b0, 8'h00, 7'd1, 7'd0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0,
                 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 7'd0, 7'd0};
    vecs[10] = '{1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0,
                 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 7'd0, 7'd0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0,
                 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 7'd1, 7'd0};

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      uart_in_valid = vecs[i].iv;
      uart_in_data = vecs[i].id;
      tx_flush = vecs[i].fl;
      core_in_ready = vecs[i].cir;
      core_out_valid = vecs[i].cov;
      core_out_data = vecs[i].cod;
      uart_out_ready = vecs[i].uor;
      #1;
      check($sformatf("v%0d_uir", i), 32'(uir), 32'(vecs[i].e_uir));
      check($sformatf("v%0d_civ", i), 32'(civ), 32'(vecs[i].e_civ));
      check($sformatf("v%0d_cid", i), 32'(cid), 32'(vecs[i].e_cid));
      check($sformatf("v%0d_cor", i), 32'(cor), 32'(vecs[i].e_cor));
      check($sformatf("v%0d_uov", i), 32'(uov), 32'(vecs[i].e_uov));
      check($sformatf("v%0d_uod", i), 32'(uod), 32'(vecs[i].e_uod));
      check($sformatf("v%0d_txl", i), 32'(txl), 32'(vecs[i].e_txl));
      check($sformatf("v%0d_rxl", i), 32'(rxl), 32'(vecs[i].e_rxl));
      check($sformatf("v%0d_b_uir", i), 32'(uir_b), 32'(vecs[i].e_uir));
      check($sformatf("v%0d_b_civ", i), 32'(civ_b), 32'(vecs[i].e_civ));
      check($sformatf("v%0d_b_cid", i), 32'(cid_b), 32'(vecs[i].e_cid));
      check($sformatf("v%0d_b_txl", i), 32'(txl_b), 32'(vecs[i].e_txl));
      check($sformatf("v%0d_b_cor", i), 32'(cor_b), 32'(vecs[i].e_cor));
    end

    // 32-byte hold then burst
    do_reset();
    core_in_ready = 1'b1;
    civ_seen = 0;
    write_bytes(32, 8'h10);
    check("hold_civ_during_writes", 32'(civ_seen), 32'(0));
    check("hold_civ_after_32", 32'(civ), 32'(0));
    check("hold_txl_32", 32'(txl), 32'(32));
    collect_tx(32, 8'h10, "burst32");
    check("burst32_idle", 32'(dut_a.r_state), 32'(IDLE));
    check("burst32_txl", 32'(txl), 32'(0));
    check("burst32_civ_low", 32'(civ), 32'(0));

    // Timeout drain of a partial burst
    do_reset();
    core_in_ready = 1'b1;
    write_bytes(5, 8'h30);
    cnt = 0;
    while (!civ && cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("timeout_delay", 32'(cnt), 32'(480));
    collect_tx(5, 8'h30, "timeout");

    // Flush, then a write during the final pop
    do_reset();
    write_bytes(3, 8'h50);
    check("flush_pre_civ", 32'(civ), 32'(0));
    @(negedge clk);
    tx_flush = 1'b1;
    @(posedge clk);
    #1;
    tx_flush = 1'b0;
    check("flush_civ", 32'(civ), 32'(1));
    @(negedge clk);
    core_in_ready = 1'b1;
    collect_tx(2, 8'h50, "flush");
    @(negedge clk);
    uart_in_valid = 1'b1;
    uart_in_data = 8'h53;
    #1;
    check("flush_last_data", 32'(cid), 32'(8'h52));
    check("flush_last_txl", 32'(txl), 32'(1));
    @(posedge clk);
    #1;
    uart_in_valid = 1'b0;
    check("flush_stay_civ", 32'(civ), 32'(1));
    check("flush_stay_state", 32'(dut_a.r_state), 32'(DRAIN));
    check("flush_stay_txl", 32'(txl), 32'(1));
    collect_tx(1, 8'h53, "flush_tail");
    check("flush_end_state", 32'(dut_a.r_state), 32'(IDLE));
    check("flush_end_civ", 32'(civ), 32'(0));

    // RX: backpressure (A) and drop (B), 70 bytes offered each
    do_reset();
    idx_a = 0;
    idx_b = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      core_out_valid = (idx_a < 70);
      core_out_data = idx_a[7:0];
      core_out_valid_b = (idx_b < 70);
      core_out_data_b = idx_b[7:0];
      #1;
      ra = cor;
      rb = cor_b;
      @(posedge clk);
      if (core_out_valid && ra) idx_a++;
      if (core_out_valid_b && rb) idx_b++;
    end
    #1;
    check("rxa_accepted", 32'(idx_a), 32'(64));
    check("rxa_ready_full", 32'(cor), 32'(0));
    check("rxa_level", 32'(rxl), 32'(64));
    check("rxa_ovf", 32'(ovf), 32'(0));
    check("rxb_accepted", 32'(idx_b), 32'(70));
    check("rxb_ovf", 32'(ovf_b), 32'(6));
    check("rxb_level", 32'(rxl_b), 32'(64));
    check("rxb_ready", 32'(cor_b), 32'(1));
    uart_out_ready = 1'b1;
    uart_out_ready_b = 1'b1;
    got_a = 0;
    got_b = 0;
    for (int c = 0; c < 300 && (got_a < 70 || got_b < 64); c++) begin
      @(negedge clk);
      core_out_valid = (idx_a < 70);
      core_out_data = idx_a[7:0];
      core_out_valid_b = 1'b0;
      #1;
      ra = cor;
      va = uov;
      da = uod;
      vb = uov_b;
      db = uod_b;
      @(posedge clk);
      if (va) begin
        check("rxa_data", 32'(da), 32'(got_a));
        got_a++;
      end
      if (vb) begin
        check("rxb_data", 32'(db), 32'(got_b));
        got_b++;
      end
      if (core_out_valid && ra) idx_a++;
    end
    #1;
    core_out_valid = 1'b0;
    check("rxa_got", 32'(got_a), 32'(70));
    check("rxb_got", 32'(got_b), 32'(64));
    check("rxa_empty", 32'(rxl), 32'(0));
    check("rxb_empty", 32'(rxl_b), 32'(0));
    check("rxb_ovf_hold", 32'(ovf_b), 32'(6));

    // Reset in the middle of a TX burst
    do_reset();
    write_bytes(10, 8'h60);
    @(negedge clk);
    tx_flush = 1'b1;
    core_out_valid = 1'b1;
    core_out_data = 8'h99;
    @(posedge clk);
    #1;
    tx_flush = 1'b0;
    core_out_valid = 1'b0;
    check("rst_pre_civ", 32'(civ), 32'(1));
    check("rst_pre_rxl", 32'(rxl), 32'(1));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_uir", 32'(uir), 32'(0));
    check("rst_civ", 32'(civ), 32'(0));
    check("rst_cid", 32'(cid), 32'(0));
    check("rst_cor", 32'(cor), 32'(0));
    check("rst_uov", 32'(uov), 32'(0));
    check("rst_uod", 32'(uod), 32'(0));
    check("rst_txl", 32'(txl), 32'(0));
    check("rst_rxl", 32'(rxl), 32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_txl", 32'(txl), 32'(0));
    check("post_rst_civ", 32'(civ), 32'(0));
    check("post_rst_uir", 32'(uir), 32'(1));
    core_in_ready = 1'b1;
    write_bytes(1, 8'h77);
    @(negedge clk);
    tx_flush = 1'b1;
    @(posedge clk);
    #1;
    tx_flush = 1'b0;
    collect_tx(1, 8'h77, "post_rst");
    check("post_rst_drained", 32'(civ), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
